// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        KILL,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } if_entry_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that parks a fetched instruction while decode is stalled.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  if_entry_t din,
    output if_entry_t dout,
    output logic      full
);

    // Flush wins over push so a redirect never leaves a stale entry behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            dout <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            dout <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request, IF/ID register with skid.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_id_stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_npc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;

    logic         out_free;
    logic         rsp_take;
    logic         skid_push;
    logic         skid_pop;
    logic         skid_full;
    if_entry_t    rsp_entry;
    if_entry_t    skid_entry;

    assign imem_req_valid = (state_q == REQ) && !redirect_valid;
    assign imem_req_addr  = pc_q;

    always_comb begin
        out_free      = !if_id_valid || !if_id_stall;
        rsp_take      = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
        rsp_entry.ir  = imem_rsp_data;
        rsp_entry.npc = req_pc_q + INSTR_BYTES;
        skid_push     = rsp_take && !out_free;
        skid_pop      = (state_q == HOLD) && skid_full && !if_id_stall && !redirect_valid;
    end

    fetch_skid u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (skid_push),
        .pop   (skid_pop),
        .flush (redirect_valid),
        .din   (rsp_entry),
        .dout  (skid_entry),
        .full  (skid_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            if_id_valid <= 1'b0;
            if_id_ir    <= '0;
            if_id_npc   <= '0;
        end else if (redirect_valid) begin
            // A request still in flight must be drained before the next one goes out.
            pc_q        <= redirect_pc;
            if_id_valid <= 1'b0;
            state_q     <= (state_q == WAIT && !imem_rsp_valid) ? KILL : REQ;
        end else begin
            unique case (state_q)
                REQ: begin
                    if (imem_req_ready) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + INSTR_BYTES;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state_q <= out_free ? REQ : HOLD;
                    end
                end
                KILL: begin
                    if (imem_rsp_valid) begin
                        state_q <= REQ;
                    end
                end
                HOLD: begin
                    if (!if_id_stall) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= REQ;
            endcase

            if (out_free) begin
                if (rsp_take) begin
                    if_id_valid <= 1'b1;
                    if_id_ir    <= rsp_entry.ir;
                    if_id_npc   <= rsp_entry.npc;
                end else if (skid_pop) begin
                    if_id_valid <= 1'b1;
                    if_id_ir    <= skid_entry.ir;
                    if_id_npc   <= skid_entry.npc;
                end else begin
                    if_id_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (rsp_take) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (if_id_valid && if_id_stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a transaction-level reference model and memory responder.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_stall;
    logic        if_id_valid;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int          checks;
    int          errors;
    int          rsp_lat;
    logic        override_en;
    logic [31:0] override_data;

    fetch_stage #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_stall    (if_id_stall),
        .if_id_valid    (if_id_valid),
        .if_id_ir       (if_id_ir),
        .if_id_npc      (if_id_npc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory: answers each accepted request rsp_lat cycles later.
    initial begin : responder
        int          cnt;
        logic [31:0] data;
        cnt            = 0;
        data           = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (reset && imem_req_valid && imem_req_ready) begin
                cnt  = rsp_lat;
                data = override_en ? override_data : mem_word(imem_req_addr);
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = (cnt == 1);
            imem_rsp_data  = (cnt == 1) ? data : 32'h0;
            if (cnt > 0) cnt--;
        end
    end

    // Reference model: tracks the architectural PC, the outstanding request, and the
    // queue of captured instructions not yet shown to decode.
    initial begin : model
        logic [31:0] m_pc;
        logic [31:0] out_addr;
        logic [31:0] cur_ir;
        logic [31:0] cur_npc;
        logic [31:0] m_fetched;
        logic [31:0] m_stall;
        logic [63:0] q[$];
        logic        outstanding;
        logic        killed;
        logic        exp_valid;
        logic        hold;
        logic        req_exp;
        logic        captured;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_pc        = RST_PC;
                out_addr    = '0;
                cur_ir      = '0;
                cur_npc     = '0;
                m_fetched   = '0;
                m_stall     = '0;
                outstanding = 1'b0;
                killed      = 1'b0;
                exp_valid   = 1'b0;
                q.delete();
            end else begin
                req_exp = !outstanding && (q.size() == 0) && !redirect_valid;
                chk1("req_valid", imem_req_valid, req_exp);
                if (imem_req_valid) chk("req_addr", imem_req_addr, m_pc);
                chk1("if_id_valid", if_id_valid, exp_valid);
                if (exp_valid) begin
                    chk("if_id_ir", if_id_ir, cur_ir);
                    chk("if_id_npc", if_id_npc, cur_npc);
                end
`ifdef FETCH_PERF_CNT_EN
                chk("perf_fetched", perf_fetched, m_fetched);
                chk("perf_stall", perf_stall, m_stall);
`endif
                hold = exp_valid && if_id_stall;
                if (hold) m_stall++;
                if (redirect_valid) begin
                    if (outstanding && imem_rsp_valid) outstanding = 1'b0;
                    else if (outstanding) killed = 1'b1;
                    m_pc      = redirect_pc;
                    exp_valid = 1'b0;
                    q.delete();
                end else begin
                    captured = 1'b0;
                    if (outstanding && imem_rsp_valid) begin
                        outstanding = 1'b0;
                        if (!killed) begin
                            m_fetched++;
                            if (hold) begin
                                q.push_back({imem_rsp_data, out_addr + 32'd4});
                            end else begin
                                cur_ir   = imem_rsp_data;
                                cur_npc  = out_addr + 32'd4;
                                captured = 1'b1;
                            end
                        end
                        killed = 1'b0;
                    end
                    if (captured || hold) begin
                        exp_valid = 1'b1;
                    end else if (q.size() > 0) begin
                        {cur_ir, cur_npc} = q.pop_front();
                        exp_valid         = 1'b1;
                    end else begin
                        exp_valid = 1'b0;
                    end
                    if (req_exp && imem_req_ready) begin
                        outstanding = 1'b1;
                        killed      = 1'b0;
                        out_addr    = m_pc;
                        m_pc        = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_id_stall    = 1'b0;
        rsp_lat        = 1;
        override_en    = 1'b0;
        override_data  = '0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rst_valid", if_id_valid, 1'b0);
        chk("rst_ir", if_id_ir, 32'h0);
        chk("rst_npc", if_id_npc, 32'h0);
        chk("rst_addr", imem_req_addr, 32'h0000_0100);

        // Back-to-back fetch from RESET_PC.
        tick(); reset = 1'b1;                                   // c0
        @(negedge clk);
        chk1("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, 32'h0000_0100);
        tick(); tick();                                         // c2
        @(negedge clk);
        chk1("c2_valid", if_id_valid, 1'b1);
        chk("c2_npc", if_id_npc, 32'h0000_0104);
        chk("c2_ir", if_id_ir, 32'hC0DE_0100);
        chk("c2_addr", imem_req_addr, 32'h0000_0104);
        tick(); tick();                                         // c4
        @(negedge clk);
        chk("c4_npc", if_id_npc, 32'h0000_0108);
        chk("c4_ir", if_id_ir, 32'hC0DE_0104);
        chk("c4_addr", imem_req_addr, 32'h0000_0108);

        // Five-cycle stall with the next instruction parked in the skid.
        tick(); tick(); if_id_stall = 1'b1;                     // c6
        repeat (4) tick();                                      // c10
        tick(); if_id_stall = 1'b0;                             // c11
        rsp_lat = 3; override_en = 1'b1; override_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stall_hold_npc", if_id_npc, 32'h0000_010C);
        chk1("hold_no_req", imem_req_valid, 1'b0);
        tick();                                                 // c12
        @(negedge clk);
        chk("skid_npc", if_id_npc, 32'h0000_0110);
        chk("skid_ir", if_id_ir, 32'hC0DE_010C);
        chk1("resume_req", imem_req_valid, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_5", perf_stall, 32'd5);
`endif

        // Redirect in WAIT; late 0xDEADBEEF response must be killed.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;   // c13
        rsp_lat = 1;
        tick(); redirect_valid = 1'b0; override_en = 1'b0;            // c14
        @(negedge clk);
        chk1("redir_valid0", if_id_valid, 1'b0);
        chk1("kill_no_req", imem_req_valid, 1'b0);
        tick(); tick();                                         // c16
        @(negedge clk);
        chk1("redir_req_valid", imem_req_valid, 1'b1);
        chk("redir_req_addr", imem_req_addr, 32'h0000_2000);
        chk1("killed_not_shown", if_id_valid, 1'b0);
        tick(); tick(); if_id_stall = 1'b1;                     // c18
        @(negedge clk);
        chk("c18_npc", if_id_npc, 32'h0000_2004);
        chk("c18_ir", if_id_ir, 32'hC0DE_2000);

        // Redirect while in HOLD with decode stalled.
        tick(); tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;  // c20
        @(negedge clk);
        chk1("hold_redir_req", imem_req_valid, 1'b0);
        tick(); redirect_valid = 1'b0;                          // c21
        @(negedge clk);
        chk1("flush_valid0", if_id_valid, 1'b0);
        chk("flush_req_addr", imem_req_addr, 32'h0000_3000);
        tick(); if_id_stall = 1'b0;                             // c22
        tick(); imem_req_ready = 1'b0;                          // c23
        @(negedge clk);
        chk("c23_npc", if_id_npc, 32'h0000_3004);
        chk("c23_ir", if_id_ir, 32'hC0DE_3000);

        // Memory back-pressure for three cycles.
        tick(); tick();                                         // c25
        @(negedge clk);
        chk1("bp_req_valid", imem_req_valid, 1'b1);
        chk("bp_req_addr", imem_req_addr, 32'h0000_3004);
        tick(); imem_req_ready = 1'b1;                          // c26
        tick();                                                 // c27
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;  // c28
        @(negedge clk);
        chk("bp_npc", if_id_npc, 32'h0000_3008);
        chk("bp_ir", if_id_ir, 32'hC0DE_3004);

        // PC wrap at the top of the address space.
        tick(); redirect_valid = 1'b0;                          // c29
        @(negedge clk);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick(); rsp_lat = 4;                                    // c30
        tick();                                                 // c31
        @(negedge clk);
        chk("wrap_npc", if_id_npc, 32'h0000_0000);
        chk("wrap_ir", if_id_ir, 32'h3F21_FFFC);
        chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);

        // Asynchronous reset while a request is outstanding.
        tick(); reset = 1'b0; imem_req_ready = 1'b0;            // c32
        @(negedge clk);
        chk1("mid_rst_valid", if_id_valid, 1'b0);
        chk("mid_rst_ir", if_id_ir, 32'h0);
        chk("mid_rst_npc", if_id_npc, 32'h0);
        chk("mid_rst_addr", imem_req_addr, 32'h0000_0100);
`ifdef FETCH_PERF_CNT_EN
        chk("mid_rst_perf", perf_fetched, 32'h0);
`endif
        tick(); tick(); reset = 1'b1;                           // c34
        @(negedge clk);
        chk1("post_rst_req", imem_req_valid, 1'b1);
        tick(); tick(); imem_req_ready = 1'b1; rsp_lat = 1;     // c36
        @(negedge clk);
        chk1("stray_ignored", if_id_valid, 1'b0);
        chk("post_rst_addr", imem_req_addr, 32'h0000_0100);
        tick(); tick();                                         // c38
        @(negedge clk);
        chk("post_rst_npc", if_id_npc, 32'h0000_0104);
        chk("post_rst_ir", if_id_ir, 32'hC0DE_0100);
`ifdef FETCH_PERF_CNT_EN
        chk("post_rst_perf", perf_fetched, 32'd1);
`endif
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
